// File: rtl/matrix_scroll_feeder_pkg.sv
// Shared types for the LED matrix datapath: a column of eight row pixels and a
// frame of eight row patterns, used by the feeder and the downstream scanner.
package matrix_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;

    typedef logic [7:0] col_t;
    typedef col_t frame_t [0:7];

    // Moves one row pattern a column left and enters a new pixel at the right edge
    function automatic col_t shift_in(input col_t row_pattern, input logic pixel);
        return {row_pattern[MATRIX_COLS-2:0], pixel};
    endfunction

endpackage

// File: rtl/matrix_scroll_feeder_col_fifo.sv
// Small synchronous column FIFO with a registered occupancy count. Reads come
// straight from storage, so the head reflects registered state only.
module col_fifo
    import matrix_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  col_t                   din,
    input  logic                   pop,
    output col_t                   dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    col_t          mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == CW'(0));
    assign push_ok_s = push && !full && !flush;
    assign pop_ok_s  = pop && !empty && !flush;
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Column storage
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/matrix_scroll_feeder.sv
// Feeds the 8x8 row scanner: buffers incoming pixel columns and, once per scroll
// step, shifts the displayed frame left with the next column entering on the right.
module matrix_scroll_feeder
    import matrix_pkg::*;
#(
    parameter int STEP_TICKS = 2500000,
    parameter int DEPTH      = 4,
    parameter bit FILL_BLANK = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [7:0]             in_col,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             m0,
    output logic [7:0]             m1,
    output logic [7:0]             m2,
    output logic [7:0]             m3,
    output logic [7:0]             m4,
    output logic [7:0]             m5,
    output logic [7:0]             m6,
    output logic [7:0]             m7,
    output logic                   step_pulse,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(STEP_TICKS - 1);

    logic [TW-1:0] tick_r;
    frame_t        frame_r;
    logic          step_pulse_r;
    col_t          head_s;
    col_t          shift_col_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          step_s;
    logic          shift_s;

    assign step_s   = enable && (tick_r == LAST_TICK);
    assign in_ready = !reset && !full_s;
    assign push_s   = in_valid && in_ready && !clear;

    col_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (clear),
        .push  (push_s),
        .din   (in_col),
        .pop   (pop_s),
        .dout  (head_s),
        .count (fifo_count),
        .full  (full_s),
        .empty (empty_s)
    );

    // Chooses whether a step shifts and which column enters at the right edge
    always_comb begin
        pop_s       = 1'b0;
        shift_s     = 1'b0;
        shift_col_s = 8'h00;
        if (step_s && !clear) begin
            if (!empty_s) begin
                pop_s       = 1'b1;
                shift_s     = 1'b1;
                shift_col_s = head_s;
            end else begin
                shift_s     = FILL_BLANK;
                shift_col_s = 8'h00;
            end
        end else begin
            shift_s = 1'b0;
        end
    end

    // Scroll-step timebase; holds its count while paused
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            tick_r <= '0;
        end else if (enable) begin
            tick_r <= (tick_r == LAST_TICK) ? TW'(0) : tick_r + TW'(1);
        end
    end

    // Frame registers and the step pulse update on the same edge
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            for (int k = 0; k < MATRIX_ROWS; k++) frame_r[k] <= 8'h00;
            step_pulse_r <= 1'b0;
        end else begin
            step_pulse_r <= shift_s;
            if (shift_s) begin
                for (int k = 0; k < MATRIX_ROWS; k++)
                    frame_r[k] <= shift_in(frame_r[k], shift_col_s[k]);
            end
        end
    end

    assign m0         = frame_r[0];
    assign m1         = frame_r[1];
    assign m2         = frame_r[2];
    assign m3         = frame_r[3];
    assign m4         = frame_r[4];
    assign m5         = frame_r[5];
    assign m6         = frame_r[6];
    assign m7         = frame_r[7];
    assign step_pulse = step_pulse_r;

endmodule

// File: tb/tb_matrix_scroll_feeder.sv
// Bench for matrix_scroll_feeder: a blank-filling and a step-skipping instance share
// stimulus; a column scoreboard predicts each shifted frame and the FIFO occupancy.
module tb_matrix_scroll_feeder;

    localparam int STEP_TICKS = 4;
    localparam int DEPTH      = 4;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          clear;
    logic [7:0]    in_col;
    logic          in_valid;
    logic          in_ready_a;
    logic          in_ready_b;
    logic [63:0]   fr_a;
    logic [63:0]   fr_b;
    logic          step_a;
    logic          step_b;
    logic [CW-1:0] fifo_count_a;
    logic [CW-1:0] fifo_count_b;

    int checks = 0;
    int errors = 0;
    int nb_pulses = 0;
    int nb_base = 0;

    logic [7:0]  exp_q [$];
    logic [63:0] model_fr = 64'h0;
    logic [7:0]  sb_col;
    logic        pend_wipe = 1'b0;
    logic        pend_push = 1'b0;
    logic [7:0]  pend_col = 8'h00;

    matrix_scroll_feeder #(.STEP_TICKS(STEP_TICKS), .DEPTH(DEPTH), .FILL_BLANK(1'b1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .in_col(in_col), .in_valid(in_valid), .in_ready(in_ready_a),
        .m0(fr_a[7:0]), .m1(fr_a[15:8]), .m2(fr_a[23:16]), .m3(fr_a[31:24]),
        .m4(fr_a[39:32]), .m5(fr_a[47:40]), .m6(fr_a[55:48]), .m7(fr_a[63:56]),
        .step_pulse(step_a), .fifo_count(fifo_count_a)
    );

    matrix_scroll_feeder #(.STEP_TICKS(STEP_TICKS), .DEPTH(DEPTH), .FILL_BLANK(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .in_col(in_col), .in_valid(in_valid), .in_ready(in_ready_b),
        .m0(fr_b[7:0]), .m1(fr_b[15:8]), .m2(fr_b[23:16]), .m3(fr_b[31:24]),
        .m4(fr_b[39:32]), .m5(fr_b[47:40]), .m6(fr_b[55:48]), .m7(fr_b[63:56]),
        .step_pulse(step_b), .fifo_count(fifo_count_b)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    task automatic push_col(input logic [7:0] c);
        in_valid = 1'b1;
        in_col   = c;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for the next step pulse and checks how many cycles it took
    task automatic wait_pulse(input string tag, input int exp_n);
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!step_a && n < 20);
        check(tag, 64'(n), 64'(exp_n));
    endtask

    // Scoreboard: the monitor sees each edge's effects on the following falling edge
    initial forever begin
        @(negedge clock);
        if (step_b) nb_pulses++;
        if (pend_wipe) begin
            exp_q.delete();
            model_fr = 64'h0;
            check("wipe_frame", fr_a, 64'h0);
        end else if (step_a) begin
            if (exp_q.size() > 0) sb_col = exp_q.pop_front();
            else sb_col = 8'h00;
            for (int k = 0; k < 8; k++)
                model_fr[8*k +: 8] = {model_fr[8*k +: 7], sb_col[k]};
            check("scroll_frame", fr_a, model_fr);
        end
        if (pend_push) exp_q.push_back(pend_col);
        check("fifo_count", 64'(fifo_count_a), 64'(exp_q.size()));
        check("nb_fifo_count", 64'(fifo_count_b), 64'(exp_q.size()));
        check("in_ready", 64'(in_ready_a), 64'(!reset && exp_q.size() < DEPTH));
        check("nb_in_ready", 64'(in_ready_b), 64'(!reset && exp_q.size() < DEPTH));
        pend_wipe = reset || clear;
        pend_push = in_valid && !reset && !clear && (exp_q.size() < DEPTH);
        pend_col  = in_col;
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_col   = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_frame", fr_a, 64'h0);
        check("rst_count", 64'(fifo_count_a), 64'h0);
        check("rst_pulse", 64'(step_a), 64'h0);
        check("rst_ready", 64'(in_ready_a), 64'h0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 64'(in_ready_a), 64'h1);

        // Basic scroll: FF then 01
        push_col(8'hFF);
        push_col(8'h01);
        check("two_pushed", 64'(fifo_count_a), 64'h2);
        enable = 1'b1;
        wait_pulse("step1_period", 4);
        check("step1_frame", fr_a, {8{8'h01}});
        wait_pulse("step2_period", 4);
        check("step2_frame", fr_a, {{7{8'h02}}, 8'h03});
        enable = 1'b0;

        // Pause at count 2 for 10 cycles, then resume from 2
        enable = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        enable = 1'b0;
        repeat (10) begin
            @(posedge clock);
            #1;
            check("pause_hold", 64'(step_a), 64'h0);
        end
        enable = 1'b1;
        wait_pulse("resume_period", 2);
        enable = 1'b0;

        // Clear wins over a simultaneous push
        push_col(8'h11);
        check("pre_clear_count", 64'(fifo_count_a), 64'h1);
        in_valid = 1'b1;
        in_col   = 8'hAA;
        clear    = 1'b1;
        @(posedge clock);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_frame", fr_a, 64'h0);
        check("clear_nb_frame", fr_b, 64'h0);
        check("clear_count", 64'(fifo_count_a), 64'h0);

        // Fill to DEPTH; a further column is refused
        in_valid = 1'b1;
        in_col = 8'hFF; @(posedge clock); #1;
        in_col = 8'h00; @(posedge clock); #1;
        in_col = 8'h00; @(posedge clock); #1;
        in_col = 8'h00; @(posedge clock); #1;
        in_col = 8'h55;
        check("full_count", 64'(fifo_count_a), 64'h4);
        check("full_ready", 64'(in_ready_a), 64'h0);
        repeat (2) @(posedge clock);
        #1;
        check("full_hold_count", 64'(fifo_count_a), 64'h4);
        in_valid = 1'b0;

        enable = 1'b1;
        wait_pulse("full_step_period", 4);
        check("pop_count", 64'(fifo_count_a), 64'h3);
        check("pop_ready", 64'(in_ready_a), 64'h1);
        check("full_step_frame", fr_a, {8{8'h01}});
        wait_pulse("pop2_period", 4);
        check("pop2_count", 64'(fifo_count_a), 64'h2);

        // Push lands on the same edge as a step pop
        repeat (3) @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_col   = 8'h3C;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("simul_pulse", 64'(step_a), 64'h1);
        check("simul_count", 64'(fifo_count_a), 64'h2);
        check("simul_frame", fr_a, {8{8'h04}});
        enable = 1'b0;

        // Empty FIFO: blank fill versus frozen frame
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        push_col(8'hFF);
        enable = 1'b1;
        wait_pulse("fb_first_period", 4);
        check("fb_first_frame", fr_a, {8{8'h01}});
        check("nb_first_frame", fr_b, {8{8'h01}});
        #5;
        nb_base = nb_pulses;
        repeat (7) wait_pulse("fb_blank_period", 4);
        check("fb_frame_80", fr_a, {8{8'h80}});
        check("nb_frozen_frame", fr_b, {8{8'h01}});
        wait_pulse("fb_empty_period", 4);
        check("fb_empty_pulse", 64'(step_a), 64'h1);
        check("fb_empty_frame", fr_a, 64'h0);
        check("nb_still_frozen", fr_b, {8{8'h01}});
        enable = 1'b0;
        #5;
        check("nb_no_pulse", 64'(nb_pulses - nb_base), 64'h0);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
